// File: rtl/enemy_blt_sprite_engine.sv
// N-channel bullet sprite engine: frame-latched positions, lowest-index hit select,
// animated sprite-sheet ROM addressing, transparency keying. Optional: ENEMY_BLT_COLLIDE_EN.
module enemy_blt_sprite_engine #(
    parameter int N_BLT       = 15,
    parameter int XW          = 9,
    parameter int YW          = 9,
    parameter int X_OFS       = 160,
    parameter int SPR_W       = 15,
    parameter int SPR_H       = 15,
    parameter int ANIM_FRAMES = 2,
    parameter int ANIM_PERIOD = 8,
    parameter int ROM_AW      = 13,
    parameter int PIX_W       = 9,
    parameter int ROM_LAT     = 1,
    parameter int TRANSP      = 0,
    localparam int IW         = (N_BLT > 1) ? $clog2(N_BLT) : 1
) (
    input  logic                  clk_25MHz,
    input  logic                  rst_n,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic                  frame_start,
    input  logic [N_BLT*XW-1:0]   enemy_blt_x,
    input  logic [N_BLT*YW-1:0]   enemy_blt_y,
    input  logic [N_BLT-1:0]      enemy_blt_vi,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic [PIX_W-1:0]      enemy_blt_pixel,
    output logic                  enemy_blt_valid,
    output logic [IW-1:0]         enemy_blt_idx
`ifdef ENEMY_BLT_COLLIDE_EN
    ,
    input  logic                  player_valid,
    output logic                  hit_flag,
    output logic [IW-1:0]         hit_idx
`endif
);
    localparam int MW  = (XW > YW) ? XW : YW;
    localparam int CW  = ((MW > 10) ? MW : 10) + 2;
    localparam int DW  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int FW  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int ROW = SPR_W * ANIM_FRAMES;

    logic [N_BLT*XW-1:0] x_s, x_p1;
    logic [N_BLT*YW-1:0] y_s, y_p1;
    logic [N_BLT-1:0]    vi_s, hit_c, hit_p1;
    logic [DW-1:0]       anim_div;
    logic [FW-1:0]       anim_frame;
    logic [9:0]          h_p1, v_p1;
    logic                any_c, vld_p2;
    logic [IW-1:0]       sel_c, idx_p2;
    logic [CW-1:0]       dx_c, dy_c;
    logic [ROM_LAT-1:0]  vld_dly;
    logic [IW-1:0]       idx_dly [ROM_LAT];
    logic                opaque;

    // Widened compare so a sprite near the right/bottom edge clips instead of wrapping.
    function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                    input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [CW-1:0] xl, yt;
        xl = CW'(x) + CW'(X_OFS);
        yt = CW'(y);
        return (CW'(h) >= xl) && (CW'(h) < xl + CW'(SPR_W)) &&
               (CW'(v) >= yt) && (CW'(v) < yt + CW'(SPR_H));
    endfunction

    function automatic logic [ROM_AW-1:0] sheet_addr(input logic [CW-1:0] dy,
                                                     input logic [CW-1:0] dx,
                                                     input logic [FW-1:0] frm);
        logic [31:0] a;
        a = 32'(dy) * 32'(ROW) + 32'(frm) * 32'(SPR_W) + 32'(dx);
        return a[ROM_AW-1:0];
    endfunction

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            vi_s       <= '0;
            anim_div   <= '0;
            anim_frame <= '0;
        end else if (frame_start) begin
            vi_s <= enemy_blt_vi;
            if (anim_div == DW'(ANIM_PERIOD - 1)) begin
                anim_div   <= '0;
                anim_frame <= (anim_frame == FW'(ANIM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
            end else begin
                anim_div <= anim_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (frame_start) begin
            x_s <= enemy_blt_x;
            y_s <= enemy_blt_y;
        end
    end

    always_comb begin
        for (int i = 0; i < N_BLT; i++)
            hit_c[i] = vi_s[i] & in_box(h_cnt, v_cnt, x_s[i*XW +: XW], y_s[i*YW +: YW]);
    end

    // S1: per-channel hit flags plus the raster and coordinates they were computed from
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) hit_p1 <= '0;
        else        hit_p1 <= hit_c;
    end

    always_ff @(posedge clk_25MHz) begin
        h_p1 <= h_cnt;
        v_p1 <= v_cnt;
        x_p1 <= x_s;
        y_p1 <= y_s;
    end

    always_comb begin
        any_c = 1'b0;
        sel_c = '0;
        dx_c  = '0;
        dy_c  = '0;
        for (int i = N_BLT - 1; i >= 0; i--) begin
            if (hit_p1[i]) begin
                any_c = 1'b1;
                sel_c = IW'(i);
                dx_c  = CW'(h_p1) - CW'(x_p1[i*XW +: XW]) - CW'(X_OFS);
                dy_c  = CW'(v_p1) - CW'(y_p1[i*YW +: YW]);
            end
        end
    end

    // S2: winning channel and sprite-sheet address
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            vld_p2   <= 1'b0;
            idx_p2   <= '0;
        end else begin
            rom_addr <= any_c ? sheet_addr(dy_c, dx_c, anim_frame) : '0;
            vld_p2   <= any_c;
            idx_p2   <= any_c ? sel_c : '0;
        end
    end

    // ROM latency: valid/idx follow the address through the external ROM
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            vld_dly <= '0;
            for (int k = 0; k < ROM_LAT; k++) idx_dly[k] <= '0;
        end else begin
            vld_dly[0] <= vld_p2;
            idx_dly[0] <= idx_p2;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_dly[k] <= vld_dly[k-1];
                idx_dly[k] <= idx_dly[k-1];
            end
        end
    end

    assign opaque = vld_dly[ROM_LAT-1] && (rom_data != PIX_W'(TRANSP));

    // Output: transparent pixels of the winning sprite still occlude higher channels
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            enemy_blt_valid <= 1'b0;
            enemy_blt_pixel <= '0;
            enemy_blt_idx   <= '0;
        end else begin
            enemy_blt_valid <= opaque;
            enemy_blt_pixel <= opaque ? rom_data : '0;
            enemy_blt_idx   <= opaque ? idx_dly[ROM_LAT-1] : '0;
        end
    end

`ifdef ENEMY_BLT_COLLIDE_EN
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hit_flag <= 1'b0;
            hit_idx  <= '0;
        end else if (frame_start) begin
            hit_flag <= 1'b0;
            hit_idx  <= '0;
        end else if (enemy_blt_valid && player_valid) begin
            hit_flag <= 1'b1;
            if (!hit_flag) hit_idx <= enemy_blt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_enemy_blt_sprite_engine.sv
// Bench for enemy_blt_sprite_engine: directed literal probes, then randomized tables and
// raster against a frame-level reference model; default build (collision logic absent).
module tb_enemy_blt_sprite_engine;
    localparam int N    = 15;
    localparam int HMAX = 16384;

    typedef struct packed {
        logic        hit;
        logic [3:0]  idx;
        logic [12:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        frame_start;
    logic [N*9-1:0] x_bus, y_bus;
    logic [N-1:0]   bvi;
    logic [8:0]  bx [N];
    logic [8:0]  by [N];
    logic [12:0] rom_addr;
    logic [8:0]  rom_data = '0;
    logic [8:0]  pixel;
    logic        valid;
    logic [3:0]  idx;

    int errors = 0;
    int checks = 0;

    enemy_blt_sprite_engine dut (
        .clk_25MHz      (clk),
        .rst_n          (rst_n),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .frame_start    (frame_start),
        .enemy_blt_x    (x_bus),
        .enemy_blt_y    (y_bus),
        .enemy_blt_vi   (bvi),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .enemy_blt_pixel(pixel),
        .enemy_blt_valid(valid),
        .enemy_blt_idx  (idx)
    );

    always #20 clk = ~clk;

    always_comb begin
        x_bus = '0;
        y_bus = '0;
        for (int i = 0; i < N; i++) begin
            x_bus[i*9 +: 9] = bx[i];
            y_bus[i*9 +: 9] = by[i];
        end
    end

    // Sprite ROM contents: addresses with a%7==3 hold the transparent value 0
    function automatic logic [8:0] romf(input int a);
        if (a % 7 == 3) return 9'd0;
        return 9'(((a * 37 + 1) & 511) | 1);
    endfunction

    always @(posedge clk) rom_data <= romf(int'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each sampled raster position should produce
    int   sx [N];
    int   sy [N];
    bit   svi [N];
    int   npulse = 0;
    ent_t hist [HMAX];
    int   ec = 0;
    int   last_rst = -1;

    always @(posedge clk) begin
        ent_t e;
        int wi, dx, dy, hh, vv;
        e = '0; wi = -1; dx = 0; dy = 0;
        hh = int'(h_cnt); vv = int'(v_cnt);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) svi[i] = 1'b0;
            npulse = 0;
            last_rst = ec;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (svi[i] && hh >= sx[i] + 160 && hh < sx[i] + 175 && vv >= sy[i] && vv < sy[i] + 15)
                    wi = i;
            if (wi >= 0) begin
                dx = hh - sx[wi] - 160;
                dy = vv - sy[wi];
            end
            if (frame_start) begin
                for (int i = 0; i < N; i++) begin
                    sx[i] = int'(bx[i]); sy[i] = int'(by[i]); svi[i] = bvi[i];
                end
                npulse++;
            end
            if (wi >= 0) begin
                e.hit  = 1'b1;
                e.idx  = 4'(wi);
                e.addr = 13'((dy * 30 + ((npulse / 8) % 2) * 15 + dx) % 8192);
            end
        end
        if (ec < HMAX) hist[ec] = e;
        ec++;
    end

    function automatic ent_t lookup(input int m);
        if (m < 0 || m <= last_rst || m >= HMAX) return '0;
        return hist[m];
    endfunction

    initial begin
        int n, ev, ep;
        ent_t ea, eo;
        forever begin
            @(posedge clk); #1;
            n  = ec - 1;
            ea = lookup(n - 1);
            eo = lookup(n - 3);
            ev = (eo.hit && romf(int'(eo.addr)) != 0) ? 1 : 0;
            ep = ev ? int'(romf(int'(eo.addr))) : 0;
            chk("cyc_rom_addr", int'(rom_addr), int'(ea.addr));
            chk("cyc_valid", int'(valid), ev);
            chk("cyc_pixel", int'(pixel), ep);
            chk("cyc_idx", int'(idx), ev ? int'(eo.idx) : 0);
        end
    end

    task automatic drive(input int h, input int v, input bit fs);
        @(negedge clk);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        frame_start = fs;
    endtask

    task automatic pulse();
        drive(0, 1000, 1'b1);
        drive(0, 1000, 1'b0);
    endtask

    task automatic probe(input string name, input int h, input int v, input int ea,
                         input int ev, input int ei, input int epix);
        drive(h, v, 1'b0);
        drive(0, 1000, 1'b0);
        @(posedge clk); #1;
        chk({name, "_addr"}, int'(rom_addr), ea);
        @(posedge clk); @(posedge clk); #1;
        chk({name, "_valid"}, int'(valid), ev);
        chk({name, "_idx"}, int'(idx), ei);
        if (epix >= 0) chk({name, "_pixel"}, int'(pixel), epix);
    endtask

    task automatic rnd_chan(input int k);
        bx[k]  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 40));
        by[k]  = 9'($urandom_range(0, 40));
        bvi[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst_n = 1'b0; h_cnt = '0; v_cnt = 10'd1000; frame_start = 1'b0; bvi = '0;
        for (int i = 0; i < N; i++) begin bx[i] = '0; by[i] = '0; end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_pixel", int'(pixel), 0);
        chk("reset_idx", int'(idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        bx[0] = 9'd0; by[0] = 9'd0; bvi[0] = 1'b1;
        pulse();
        probe("t1_corner", 160, 0, 0, 1, 0, 1);

        bvi[0] = 1'b0; bx[3] = 9'd10; by[3] = 9'd20; bvi[3] = 1'b1;
        pulse();
        probe("t2_last_col", 184, 34, 434, 1, 3, 187);
        probe("t2_past_col", 185, 34, 0, 0, 0, 0);

        bvi[3] = 1'b0;
        bx[2] = 9'd50; by[2] = 9'd60; bvi[2] = 1'b1;
        bx[7] = 9'd50; by[7] = 9'd60; bvi[7] = 1'b1;
        pulse();
        probe("t3_overlap", 215, 65, 155, 1, 2, 105);
        bvi[2] = 1'b0;
        pulse();
        probe("t3_ch7", 215, 65, 155, 1, 7, -1);

        bx[7] = 9'd100;
        probe("t4_no_tear", 215, 65, 155, 1, 7, -1);
        pulse();
        probe("t4_moved", 215, 65, 0, 0, 0, 0);
        repeat (8) pulse();
        probe("t4_anim", 265, 65, 170, 1, 7, -1);

        bvi[7] = 1'b0; bx[0] = 9'd511; by[0] = 9'd100; bvi[0] = 1'b1;
        pulse();
        probe("t5_first", 671, 100, 15, 1, 0, -1);
        probe("t5_last", 685, 100, 29, 1, 0, -1);
        probe("t5_past", 686, 100, 0, 0, 0, 0);
        probe("t5_nowrap", 5, 100, 0, 0, 0, 0);
        probe("t5_transp", 673, 100, 17, 0, 0, 0);

        for (int c = 0; c < 10; c++) drive(671 + c, 100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr", int'(rom_addr), 0);
        chk("t6_rst_valid", int'(valid), 0);
        chk("t6_rst_pixel", int'(pixel), 0);
        chk("t6_rst_idx", int'(idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) rnd_chan(k);
        pulse();
        for (int it = 0; it < 3000; it++) begin
            int k;
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) rnd_chan(int'($urandom_range(0, N - 1)));
            k = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 9) == 0) begin
                h_cnt = 10'($urandom_range(0, 799));
                v_cnt = 10'($urandom_range(0, 524));
            end else begin
                h_cnt = 10'(int'(bx[k]) + 159 + int'($urandom_range(0, 17)));
                v_cnt = 10'(int'(by[k]) - 1 + int'($urandom_range(0, 17)));
            end
            frame_start = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; frame_start = 1'b0; v_cnt = 10'd1000;
        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
